// File: rtl/instruction_register.sv
// -----------------------------------------------------------------------------
// instruction_register
//
// Fetch-side instruction register for the multicycle RV32I core. When the
// control FSM pulses fetch_req, one word is fetched from instruction memory
// over a req/valid handshake. The word is then held for the rest of the
// instruction's execution. The register fields are decoded, and the raw
// (un-extended) immediate fields go to the sign_extender instances.
//
// Handshake: mem_req is high for every cycle the FSM is in REQ. The first
// cycle in REQ with mem_valid high transfers mem_rdata into instr, and
// mem_req drops on the next cycle. mem_valid is ignored outside REQ.
// fetch_req is ignored while in REQ, and fetch requests are not queued.
//
// Parameters
//   ILEN      instruction width (only 32 is supported)
//   MAX_WAIT  cycles spent in REQ before the fetch is abandoned (0 = never)
//   RESET_IR  reset value of instr (NOP)
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   fetch_req            start-fetch pulse from the control FSM
//   mem_valid, mem_rdata memory response
//   mem_req              fetch request to memory (high while in REQ)
//   ir_valid             instr holds a completed fetch
//   fetch_timeout        one-cycle pulse when a fetch is abandoned
//   instr                held instruction word
//   opcode..rs2          decoded register/opcode fields
//   imm_i/s/b/j/u        raw immediate fields (imm_u is already full width)
//   fsm_state            debug view of the FSM: 0=IDLE 1=REQ 2=HOLD
//   illegal              only with `define IR_ILLEGAL_CHECK_EN
//
// Optional feature macro: IR_ILLEGAL_CHECK_EN
// -----------------------------------------------------------------------------
module instruction_register #(
   parameter int          ILEN     = 32,
   parameter int          MAX_WAIT = 16,
   parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            fetch_req,
   input  logic            mem_valid,
   input  logic [ILEN-1:0] mem_rdata,
   output logic            mem_req,
   output logic            ir_valid,
   output logic            fetch_timeout,
   output logic [ILEN-1:0] instr,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [11:0]     imm_i,
   output logic [11:0]     imm_s,
   output logic [12:0]     imm_b,
   output logic [20:0]     imm_j,
   output logic [31:0]     imm_u,
   output logic [1:0]      fsm_state
`ifdef IR_ILLEGAL_CHECK_EN
   ,
   output logic            illegal
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // MAX_WAIT=0 would give a zero-width counter, so keep at least one bit.
   // In that configuration the counter only saturates and is never compared.
   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;
   localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ILEN-1:0]   instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              tmo_q, tmo_d;
`ifdef IR_ILLEGAL_CHECK_EN
   logic              ill_q, ill_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         instr_q <= RESET_IR;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
`ifdef IR_ILLEGAL_CHECK_EN
         ill_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
`ifdef IR_ILLEGAL_CHECK_EN
         ill_q   <= ill_d;
`endif
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      valid_d = valid_q;
      tmo_d   = 1'b0;
`ifdef IR_ILLEGAL_CHECK_EN
      ill_d   = ill_q;
`endif
      unique case (state_q)
         IDLE, HOLD: begin
            if (fetch_req) begin
               // Entering REQ invalidates the old word, but instr keeps it
               // visible until the new one arrives.
               state_d = REQ;
               cnt_d   = '0;
               valid_d = 1'b0;
`ifdef IR_ILLEGAL_CHECK_EN
               ill_d   = 1'b0;
`endif
            end
         end
         REQ: begin
            if (mem_valid) begin
               // mem_valid takes priority over a timeout in the same cycle
               state_d = HOLD;
               instr_d = mem_rdata;
               valid_d = 1'b1;
`ifdef IR_ILLEGAL_CHECK_EN
               ill_d   = (mem_rdata[1:0] != 2'b11) ||
                         (mem_rdata == 32'h0000_0000) ||
                         (mem_rdata == 32'hFFFF_FFFF);
`endif
            end else if ((MAX_WAIT != 0) && (cnt_q == LAST)) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_req       = (state_q == REQ);
   assign ir_valid      = valid_q;
   assign fetch_timeout = tmo_q;
   assign instr         = instr_q;
   assign fsm_state     = state_q;
`ifdef IR_ILLEGAL_CHECK_EN
   assign illegal       = ill_q;
`endif

   // Field decode: pure wiring from the held word
   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];
   assign rd     = instr_q[11:7];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign imm_i  = instr_q[31:20];
   assign imm_s  = {instr_q[31:25], instr_q[11:7]};
   assign imm_b  = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_j  = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
   assign imm_u  = {instr_q[31:12], 12'b0};

endmodule

// File: tb/tb_instruction_register.sv
module tb_instruction_register;

  localparam int MAX_WAIT = 16;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        ir_valid;
  logic        fetch_timeout;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [12:0] imm_b;
  logic [20:0] imm_j;
  logic [31:0] imm_u;
  logic [1:0]  fsm_state;
`ifdef IR_ILLEGAL_CHECK_EN
  logic        illegal;
`endif

  instruction_register #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .ir_valid(ir_valid), .fetch_timeout(fetch_timeout),
    .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_j(imm_j), .imm_u(imm_u),
    .fsm_state(fsm_state)
`ifdef IR_ILLEGAL_CHECK_EN
    , .illegal(illegal)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;
  logic        exp_valid;
  logic        exp_ill;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fields straight from the instruction-format definitions
  task automatic check_fields(input logic [31:0] w);
    chk("opcode", {25'b0, opcode}, {25'b0, w[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
    chk("funct7", {25'b0, funct7}, {25'b0, w[31:25]});
    chk("rd",     {27'b0, rd},     {27'b0, w[11:7]});
    chk("rs1",    {27'b0, rs1},    {27'b0, w[19:15]});
    chk("rs2",    {27'b0, rs2},    {27'b0, w[24:20]});
    chk("imm_i",  {20'b0, imm_i},  {20'b0, w[31:20]});
    chk("imm_s",  {20'b0, imm_s},  {20'b0, w[31:25], w[11:7]});
    chk("imm_b",  {19'b0, imm_b},  {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0});
    chk("imm_j",  {11'b0, imm_j},  {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0});
    chk("imm_u",  imm_u,           {w[31:12], 12'b0});
  endtask

  // The debug state is non-IDLE exactly when a fetch is pending or held
  task automatic check_state_view();
    chk("dbg_state", {31'b0, (fsm_state != 2'd0)}, {31'b0, (exp_valid | mem_req)});
  endtask

  task automatic check_ill();
`ifdef IR_ILLEGAL_CHECK_EN
    chk("illegal", {31'b0, illegal}, {31'b0, exp_ill});
`endif
  endtask

  // One fetch transaction: mem_valid arrives after `delay` idle REQ cycles
  // (abandoned if that exceeds the wait budget). noise=1 also pulses
  // fetch_req during REQ, which must have no effect.
  task automatic do_fetch(input logic [31:0] data, input int delay, input bit noise);
    bit done;
    int k;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    exp_valid = 1'b0;
    exp_ill   = 1'b0;
    done = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      chk("mem_req_in_req", {31'b0, mem_req}, 32'd1);
      chk("ir_valid_in_req", {31'b0, ir_valid}, 32'd0);
      chk("instr_held_in_req", instr, exp_instr);
      if (k == delay) begin
        mem_valid = 1'b1;
        mem_rdata = data;
        exp_q.push_back(data);
        step();
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        exp_instr = exp_q.pop_front();
        exp_valid = 1'b1;
        exp_ill = (exp_instr[1:0] != 2'b11) || (exp_instr == 32'h0) ||
                  (exp_instr == 32'hFFFF_FFFF);
        chk("instr_latched", instr, exp_instr);
        chk("ir_valid_set", {31'b0, ir_valid}, 32'd1);
        chk("mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("no_timeout", {31'b0, fetch_timeout}, 32'd0);
        check_fields(exp_instr);
        check_ill();
        check_state_view();
        done = 1'b1;
      end else if (MAX_WAIT != 0 && k == MAX_WAIT - 1) begin
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        fetch_req = 1'b0;
        chk("timeout_pulse", {31'b0, fetch_timeout}, 32'd1);
        chk("timeout_mem_req", {31'b0, mem_req}, 32'd0);
        chk("timeout_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("timeout_instr", instr, exp_instr);
        step();
        chk("timeout_one_cycle", {31'b0, fetch_timeout}, 32'd0);
        chk("timeout_idle", {31'b0, mem_req}, 32'd0);
        check_state_view();
        done = 1'b1;
      end else begin
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        fetch_req = 1'b0;
        chk("no_early_timeout", {31'b0, fetch_timeout}, 32'd0);
        check_state_view();
      end
      k++;
    end
    if (!done) chk("fetch_bound", 32'd0, 32'd1);
  endtask

  // mem_valid outside REQ must be ignored
  task automatic stray_valid(input logic [31:0] data);
    mem_valid = 1'b1;
    mem_rdata = data;
    step();
    mem_valid = 1'b0;
    chk("stray_instr", instr, exp_instr);
    chk("stray_ir_valid", {31'b0, ir_valid}, {31'b0, exp_valid});
    chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    fetch_req = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    exp_instr = 32'h0000_0013;
    exp_valid = 1'b0;
    exp_ill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_timeout", {31'b0, fetch_timeout}, 32'd0);
    check_ill();
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Minimum latency fetch of addi x1,x0,-1
    do_fetch(32'hFFF0_0093, 0, 1'b0);
    chk("t2_imm_i", {20'b0, imm_i}, 32'h0000_0FFF);
    chk("t2_rd", {27'b0, rd}, 32'd1);
    chk("t2_opcode", {25'b0, opcode}, 32'h13);

    do_fetch(32'h8000_006F, 2, 1'b0);
    chk("t3_imm_j", {11'b0, imm_j}, 32'h0010_0000);
    do_fetch(32'hFE00_0EE3, 1, 1'b0);
    chk("t3_imm_b", {19'b0, imm_b}, 32'h0000_1FFC);

    stray_valid(32'h1234_5678);        // in HOLD
    do_fetch(32'hDEAD_BEEF, 100, 1'b1); // abandoned, fetch_req noise in REQ
    stray_valid(32'h1234_5678);        // in IDLE
    do_fetch(32'h0040_0113, MAX_WAIT - 1, 1'b1); // valid on the timeout cycle
    do_fetch(32'h0000_0000, 0, 1'b0);
    do_fetch(32'h0000_0013, 3, 1'b0);
    do_fetch(32'hFFFF_FFFF, 0, 1'b0);

    // Asynchronous reset in the middle of a fetch
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    exp_instr = 32'h0000_0013;
    exp_valid = 1'b0;
    exp_ill = 1'b0;
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    check_ill();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("arst_idle", {31'b0, mem_req}, 32'd0);
    check_state_view();

    // Randomized fetches
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      int d;
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w = 32'h0000_0000;
      d = $urandom_range(0, MAX_WAIT + 4);
      do_fetch(w, d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) stray_valid($urandom);
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("idle_stable", instr, exp_instr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the sequence above stalls
  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got=stalled expected=finished");
    $fatal(1, "time limit");
  end

endmodule
